cnn_layer_accel_weight_seq_ctrl: RTL and testbench
==================================================

Name: cnn_layer_accel_weight_seq_ctrl

Overview:
- Reader/driver side of the weight sequence data table.
- Walks the table's entry indices once per kernel pass and consumes the paired sequence values (dout0/dout1).
- Offsets each value by a per-pass kernel base address and presents the resulting weight-RAM read-address pairs downstream on a valid/ready interface.
- Sits between the layer control FSM (start/done) and the weight buffer read ports.

Parameters:
- C_NUM_SEQ_VALUES, 5, table entries per pass (matches `NUM_WHT_SEQ_VALUES).
- C_SEQ_WIDTH, 4, table value width (matches `WHT_SEQ_WIDTH).
- C_WHT_ADDR_WIDTH, 12, weight RAM address width.
- C_KRNL_CNT_WIDTH, 10, width of the pass-count input.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  1-cycle pulse; ignored unless idle
- num_kernels  in  C_KRNL_CNT_WIDTH  passes to run; sampled at start
- krnl_base_addr  in  C_WHT_ADDR_WIDTH  first-pass base; sampled at start
- krnl_stride  in  C_WHT_ADDR_WIDTH  base increment per pass; sampled at start
- busy  out  1  high from the accepted start until done
- done  out  1  1-cycle completion pulse
- tbl_rdAddr  out  clog2(C_NUM_SEQ_VALUES)  table index
- tbl_rden  out  1  table streaming-increment strobe
- tbl_seq_dout0  in  C_SEQ_WIDTH  table value 0; valid one cycle after address
- tbl_seq_dout1  in  C_SEQ_WIDTH  table value 1
- wht_addr0  out  C_WHT_ADDR_WIDTH  base + dout0
- wht_addr1  out  C_WHT_ADDR_WIDTH  base + dout1
- wht_valid  out  1  address pair valid
- wht_ready  in  1  downstream accept

Behaviour:
- Reset values: busy=0, done=0, wht_valid=0, tbl_rden=0, tbl_rdAddr=0, wht_addr0/1=0; all counters cleared, FSM=IDLE.
- Reset asserted mid-operation aborts immediately:
  - no done pulse;
  - in-flight table data discarded;
  - buffered outputs dropped.

FSM:
- IDLE:
  - start with num_kernels!=0 -> ISSUE; latch base/stride/count.
  - start with num_kernels==0 -> DONE; done pulses next cycle, no outputs.
- ISSUE:
  - Issue one table read per cycle when credits allow.
  - Increment idx after each issue.
  - idx==C_NUM_SEQ_VALUES-1 issued -> idx wraps to 0, pass counter increments.
  - Last read of the last pass -> DRAIN.
- DRAIN: wait until in-flight reads have returned and the output buffer is empty -> DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle -> IDLE.

Table read and address formation:
- Table read latency is 1 cycle (registered read).
- The returned pair is tagged with the base of the pass that issued it.
- Output: wht_addrN = tag_base + zero-extended tbl_seq_doutN, modulo 2^C_WHT_ADDR_WIDTH.
- Base advances by krnl_stride per pass, wrapping modulo 2^C_WHT_ADDR_WIDTH.

Flow control:
- 2-entry output buffer.
- Issue only if (buffered + in-flight) < 2. No pair is ever dropped or duplicated under any wht_ready pattern.
- Throughput is 1 pair/cycle with wht_ready held high.
- Output ordering: idx 0..N-1 per pass, passes in order.
- wht_addr0/1 hold stable while wht_valid=1 and wht_ready=0.
- start while busy is ignored. No state changes; busy stays asserted.

Optional Feature:
- Macro: WHT_SEQ_PREFETCH_EN.
- Defined (streaming mode):
  - tbl_rden=1 on every issue cycle that directly follows another issue within the same pass, so the table self-increments.
  - tbl_rdAddr is presented at the pass start and after any stall.
- Undefined: tbl_rden tied 0; every read is explicitly addressed via tbl_rdAddr.
- Output sequence is identical in both builds.

Decomposition:
- Shared package/defs include holds:
  - FSM state encoding (IDLE/ISSUE/DRAIN/DONE);
  - C_NUM_SEQ_VALUES / C_SEQ_WIDTH tie-ins to `NUM_WHT_SEQ_VALUES / `WHT_SEQ_WIDTH;
  - the idx width derived via clog2.
- One sub-module: cnn_layer_accel_wht_seq_skid, the 2-entry valid/ready buffer carrying {addr0, addr1}, with full/empty/count outputs feeding credit logic.

Test Plan:
- Bench table model: entry i returns dout0=10+i, dout1=2+i.
- Basic run: base=0x100, stride=0x20, num_kernels=2, ready=1.
  - Expect 10 pairs, back-to-back from the 2nd cycle.
  - Pass 0: (0x10A,0x102)...(0x10E,0x106).
  - Pass 1: (0x12A,0x122)...(0x12E,0x126).
  - done pulses once after the last accept; busy=0 in that cycle.
- Backpressure: random wht_ready at 30% high -> identical ordered 10-pair sequence; data stable while stalled; no loss or duplication.
- Zero passes: num_kernels=0 -> wht_valid never asserts; done pulses one cycle after start.
- Address wrap: C_WHT_ADDR_WIDTH=12, base=0xFF8, stride=0x8, num_kernels=2.
  - Pass 1 base = 0x000.
  - Pass 0 first pair = (0x002,0xFFA).
- Mid-run disruptions:
  - rst asserted mid-run, with wht_ready low and buffer full -> all outputs return to reset values asynchronously; no done.
  - A second start while busy -> ignored.
- Build both with and without WHT_SEQ_PREFETCH_EN under the same stimulus -> identical transaction logs. With the macro, tbl_rden is high on all consecutive in-pass issues.

Source files
------------

// File: rtl/cnn_layer_accel_weight_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_layer_accel_weight_seq_ctrl_pkg
//  Purpose  : Shared definitions for the weight sequence controller.
//             - table geometry tied to `NUM_WHT_SEQ_VALUES / `WHT_SEQ_WIDTH
//             - table index width
//             - controller FSM state encoding
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`ifndef NUM_WHT_SEQ_VALUES
`define NUM_WHT_SEQ_VALUES 5
`endif
`ifndef WHT_SEQ_WIDTH
`define WHT_SEQ_WIDTH 4
`endif

package cnn_layer_accel_weight_seq_ctrl_pkg;

  localparam int C_NUM_SEQ_VALUES = `NUM_WHT_SEQ_VALUES;
  localparam int C_SEQ_WIDTH      = `WHT_SEQ_WIDTH;
  // Keep the index at least one bit wide even for a single-entry table.
  localparam int C_IDX_WIDTH      = (C_NUM_SEQ_VALUES > 1) ? $clog2(C_NUM_SEQ_VALUES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wseq_state_t;

endpackage

`default_nettype wire

// File: rtl/cnn_layer_accel_weight_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_layer_accel_weight_seq_ctrl_if
//  Purpose  : Bundles the controller's command, table-read and weight-address
//             signals.
//             - master : the sequencer (drives status, table address and
//                        weight address pairs)
//             - slave  : the surrounding layer logic, table and weight buffer
//  Ports    : none (signals grouped below)
//  Revision : 1.0  initial release
// ============================================================================
interface cnn_layer_accel_weight_seq_ctrl_if
  import cnn_layer_accel_weight_seq_ctrl_pkg::*;
#(
  parameter int C_WHT_ADDR_WIDTH = 12,
  parameter int C_KRNL_CNT_WIDTH = 10
);
  // command / status
  logic                        start;
  logic [C_KRNL_CNT_WIDTH-1:0] num_kernels;
  logic [C_WHT_ADDR_WIDTH-1:0] krnl_base_addr;
  logic [C_WHT_ADDR_WIDTH-1:0] krnl_stride;
  logic                        busy;
  logic                        done;
  // sequence table read port
  logic [C_IDX_WIDTH-1:0]      tbl_rdAddr;
  logic                        tbl_rden;
  logic [C_SEQ_WIDTH-1:0]      tbl_seq_dout0;
  logic [C_SEQ_WIDTH-1:0]      tbl_seq_dout1;
  // weight address pair stream
  logic [C_WHT_ADDR_WIDTH-1:0] wht_addr0;
  logic [C_WHT_ADDR_WIDTH-1:0] wht_addr1;
  logic                        wht_valid;
  logic                        wht_ready;

  modport master (
    input  start, num_kernels, krnl_base_addr, krnl_stride,
    input  tbl_seq_dout0, tbl_seq_dout1, wht_ready,
    output busy, done, tbl_rdAddr, tbl_rden, wht_addr0, wht_addr1, wht_valid
  );

  modport slave (
    output start, num_kernels, krnl_base_addr, krnl_stride,
    output tbl_seq_dout0, tbl_seq_dout1, wht_ready,
    input  busy, done, tbl_rdAddr, tbl_rden, wht_addr0, wht_addr1, wht_valid
  );

endinterface

`default_nettype wire

// File: rtl/cnn_layer_accel_wht_seq_skid.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_layer_accel_wht_seq_skid
//  Purpose  : 2-entry valid/ready FIFO carrying {addr0, addr1} pairs.
//             Head entry stays stable until popped.
//  Ports    : clk, rst            clock, async active-high reset
//             push, push_data     write one entry (never while full w/o pop)
//             pop                 remove head entry (only while not empty)
//             head_data           current head entry
//             full, empty, count  occupancy for the credit logic
//  Revision : 1.0  initial release
// ============================================================================
module cnn_layer_accel_wht_seq_skid #(
  parameter int C_DATA_WIDTH = 24
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    push,
  input  wire logic [C_DATA_WIDTH-1:0] push_data,
  input  wire logic                    pop,
  output logic      [C_DATA_WIDTH-1:0] head_data,
  output logic                         full,
  output logic                         empty,
  output logic      [1:0]              count
);

  logic [C_DATA_WIDTH-1:0] r_mem0;
  logic [C_DATA_WIDTH-1:0] r_mem1;
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        if (r_wr_ptr) r_mem1 <= push_data;
        else          r_mem0 <= push_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (pop) r_rd_ptr <= ~r_rd_ptr;
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_rd_ptr ? r_mem1 : r_mem0;
  assign count     = r_count;
  assign empty     = (r_count == 2'd0);
  assign full      = (r_count == 2'd2);

endmodule

`default_nettype wire

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_layer_accel_weight_seq_ctrl
//  Purpose  : Walks the weight sequence table once per kernel pass, offsets
//             each returned value pair by the pass base address and streams
//             the resulting weight-RAM read-address pairs downstream.
//  Ports    : clk, rst   clock, async active-high reset
//             bus        command/status, table read port, address stream
//  Options  : WHT_SEQ_PREFETCH_EN - streaming table reads (tbl_rden strobes
//             on consecutive in-pass issues); otherwise tbl_rden stays 0.
//  Revision : 1.0  initial release
// ============================================================================
module cnn_layer_accel_weight_seq_ctrl
  import cnn_layer_accel_weight_seq_ctrl_pkg::*;
#(
  parameter int C_WHT_ADDR_WIDTH = 12,
  parameter int C_KRNL_CNT_WIDTH = 10
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  cnn_layer_accel_weight_seq_ctrl_if.master bus
);

  localparam logic [C_IDX_WIDTH-1:0] c_last_idx = C_IDX_WIDTH'(C_NUM_SEQ_VALUES - 1);

  wseq_state_t                 r_state;
  wseq_state_t                 w_next_state;
  logic [C_IDX_WIDTH-1:0]      r_idx;
  logic [C_KRNL_CNT_WIDTH-1:0] r_pass;
  logic [C_KRNL_CNT_WIDTH-1:0] r_num_kernels;
  logic [C_WHT_ADDR_WIDTH-1:0] r_base;
  logic [C_WHT_ADDR_WIDTH-1:0] r_stride;
  logic [C_WHT_ADDR_WIDTH-1:0] r_tag_base;   // base of the pass that issued the in-flight read
  logic                        r_inflight;

  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  logic [1:0]                    w_count;
  logic [2:0]                    w_occupancy;
  logic                          w_credit_ok;
  logic                          w_issue;
  logic                          w_last_idx;
  logic                          w_last_pass;
  logic [2*C_WHT_ADDR_WIDTH-1:0] w_push_data;
  logic [2*C_WHT_ADDR_WIDTH-1:0] w_head_data;

  // Entries that will be held after this cycle if nothing new is issued:
  // buffered + returning read - the pair leaving now. The buffer only has
  // room for two, so an issue needs that total below two.
  assign w_pop       = ~w_empty & bus.wht_ready;
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit_ok = ~(w_full & ~w_pop) & (w_occupancy < 3'd2);
  assign w_issue     = (r_state == ST_ISSUE) & w_credit_ok;
  assign w_last_idx  = (r_idx == c_last_idx);
  assign w_last_pass = (r_pass == (r_num_kernels - C_KRNL_CNT_WIDTH'(1)));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next_state = (bus.num_kernels != '0) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (w_issue && w_last_idx && w_last_pass) w_next_state = ST_DRAIN;
      ST_DRAIN: if (!r_inflight && w_empty) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx         <= '0;
      r_pass        <= '0;
      r_num_kernels <= '0;
      r_base        <= '0;
      r_stride      <= '0;
      r_tag_base    <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag_base <= r_base;
      if (r_state == ST_IDLE && bus.start) begin
        r_idx         <= '0;
        r_pass        <= '0;
        r_num_kernels <= bus.num_kernels;
        r_base        <= bus.krnl_base_addr;
        r_stride      <= bus.krnl_stride;
      end else if (w_issue) begin
        if (w_last_idx) begin
          r_idx  <= '0;
          r_pass <= r_pass + C_KRNL_CNT_WIDTH'(1);
          r_base <= r_base + r_stride;
        end else begin
          r_idx <= r_idx + C_IDX_WIDTH'(1);
        end
      end
    end
  end

  // The explicit address is always presented; in streaming mode the table
  // ignores it whenever tbl_rden is set.
  assign bus.tbl_rdAddr = r_idx;

`ifdef WHT_SEQ_PREFETCH_EN
  // Set when the previous cycle issued a read that is not the last of its
  // pass, i.e. an issue now continues the same pass without a gap.
  logic r_prev_issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev_issue <= 1'b0;
    else     r_prev_issue <= w_issue & ~w_last_idx;
  end

  assign bus.tbl_rden = w_issue & r_prev_issue;
`else
  assign bus.tbl_rden = 1'b0;
`endif

  assign w_push_data = {r_tag_base + C_WHT_ADDR_WIDTH'(bus.tbl_seq_dout0),
                        r_tag_base + C_WHT_ADDR_WIDTH'(bus.tbl_seq_dout1)};

  cnn_layer_accel_wht_seq_skid #(
    .C_DATA_WIDTH (2*C_WHT_ADDR_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head_data (w_head_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign bus.wht_valid = ~w_empty;
  assign bus.wht_addr0 = w_head_data[2*C_WHT_ADDR_WIDTH-1:C_WHT_ADDR_WIDTH];
  assign bus.wht_addr1 = w_head_data[C_WHT_ADDR_WIDTH-1:0];
  assign bus.busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign bus.done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_layer_accel_weight_seq_ctrl
//  Purpose  : Self-checking bench for cnn_layer_accel_weight_seq_ctrl.
//             Table model: entry i returns dout0=10+i, dout1=2+i.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnn_layer_accel_weight_seq_ctrl;
  import cnn_layer_accel_weight_seq_ctrl_pkg::*;

  localparam int AW = 12;
  localparam int KW = 10;
  localparam int N  = C_NUM_SEQ_VALUES;
`ifdef WHT_SEQ_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_weight_seq_ctrl_if #(.C_WHT_ADDR_WIDTH(AW), .C_KRNL_CNT_WIDTH(KW)) bus ();

  cnn_layer_accel_weight_seq_ctrl #(
    .C_WHT_ADDR_WIDTH (AW),
    .C_KRNL_CNT_WIDTH (KW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Sequence table: registered read, self-increments when tbl_rden is set.
  logic [C_IDX_WIDTH-1:0] tbl_q;
  always @(posedge clk) tbl_q <= bus.tbl_rden ? tbl_q + 1'b1 : bus.tbl_rdAddr;
  assign bus.tbl_seq_dout0 = C_SEQ_WIDTH'(10) + C_SEQ_WIDTH'(tbl_q);
  assign bus.tbl_seq_dout1 = C_SEQ_WIDTH'(2)  + C_SEQ_WIDTH'(tbl_q);

  int vectors = 0;
  int miscompares = 0;

  logic [2*AW-1:0] exp_q[$];
  logic [2*AW-1:0] got_q[$];
  int              acc_cyc[$];
  int              done_cycle, done_count, busy_at_done, rden_count, stall_err;

  // Reference: pass p uses base + p*stride, entry i adds (10+i, 2+i).
  function automatic void build_exp(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                    input int nk);
    logic [AW-1:0] b;
    exp_q.delete();
    for (int p = 0; p < nk; p++) begin
      b = AW'(base + p * stride);
      for (int i = 0; i < N; i++) exp_q.push_back({AW'(b + 10 + i), AW'(b + 2 + i)});
    end
  endfunction

  // Runs one job; records accepted pairs, done timing and stall stability.
  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [KW-1:0] nk, input int pct, input int restart_at,
                         input int max_cycles);
    bit              prev_hold = 0;
    logic [2*AW-1:0] prev_data = '0;
    got_q.delete(); acc_cyc.delete();
    done_cycle = -1; done_count = 0; busy_at_done = 0; rden_count = 0; stall_err = 0;
    for (int k = 0; k < max_cycles; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 0) || (k == restart_at);
      if (k == 0) begin
        bus.num_kernels = nk; bus.krnl_base_addr = base; bus.krnl_stride = stride;
      end else if (k == restart_at) begin
        bus.num_kernels = nk + 3; bus.krnl_base_addr = ~base; bus.krnl_stride = stride + 1;
      end
      bus.wht_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (prev_hold && (!bus.wht_valid || {bus.wht_addr0, bus.wht_addr1} !== prev_data))
        stall_err++;
      prev_hold = bus.wht_valid && !bus.wht_ready;
      prev_data = {bus.wht_addr0, bus.wht_addr1};
      if (bus.wht_valid && bus.wht_ready) begin
        got_q.push_back({bus.wht_addr0, bus.wht_addr1});
        acc_cyc.push_back(k);
      end
      if (bus.tbl_rden) rden_count++;
      if (bus.done) begin
        done_count++;
        if (done_cycle < 0) begin done_cycle = k; busy_at_done = bus.busy; end
      end
      if (done_cycle >= 0 && k >= done_cycle + 2) break;
    end
    bus.start = 1'b0;
    bus.wht_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.num_kernels = '0; bus.krnl_base_addr = '0;
    bus.krnl_stride = '0; bus.wht_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.wht_valid, bus.tbl_rden} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/done/valid/rden=%b required 0000",
               {bus.busy, bus.done, bus.wht_valid, bus.tbl_rden});
    end
    vectors++;
    if ({bus.tbl_rdAddr, bus.wht_addr0, bus.wht_addr1} !== '0) begin
      miscompares++;
      $display("FAIL reset_addr: got rdAddr=%0h a0=%h a1=%h required all 0",
               bus.tbl_rdAddr, bus.wht_addr0, bus.wht_addr1);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_job(12'h100, 12'h020, 10'd2, 100, -1, 100);
    build_exp(12'h100, 12'h020, 2);
    vectors++;
    if (done_cycle < 0) begin miscompares++; $display("FAIL basic_timeout: done not seen, required within 100 cycles"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL basic_count: got %0d pairs required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL basic_pair[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 0) begin
      vectors++;
      if (got_q[0] !== {12'h10A, 12'h102}) begin
        miscompares++; $display("FAIL basic_first: got %h required 10a102", got_q[0]);
      end
    end
    if (acc_cyc.size() == 10) begin
      vectors++;
      if (acc_cyc[9] - acc_cyc[0] != 9) begin
        miscompares++; $display("FAIL basic_b2b: got span %0d cycles required 9", acc_cyc[9] - acc_cyc[0]);
      end
      vectors++;
      if (done_cycle <= acc_cyc[9]) begin
        miscompares++; $display("FAIL basic_done_order: got done at %0d required after %0d", done_cycle, acc_cyc[9]);
      end
    end
    vectors++;
    if (done_count != 1 || busy_at_done != 0) begin
      miscompares++; $display("FAIL basic_done: got pulses=%0d busy=%0d required 1 and 0", done_count, busy_at_done);
    end
    vectors++;
    if (rden_count != (PREFETCH ? 2 * (N - 1) : 0)) begin
      miscompares++; $display("FAIL basic_rden: got %0d strobes required %0d", rden_count, PREFETCH ? 2 * (N - 1) : 0);
    end
  endtask

  task automatic test_backpressure();
    run_job(12'h100, 12'h020, 10'd2, 30, 4, 400);
    build_exp(12'h100, 12'h020, 2);
    vectors++;
    if (got_q.size() != exp_q.size() || done_cycle < 0) begin
      miscompares++; $display("FAIL bp_count: got %0d pairs done_cycle=%0d required %0d pairs", got_q.size(), done_cycle, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL bp_pair[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (stall_err != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_err); end
    vectors++;
    if (done_count != 1) begin miscompares++; $display("FAIL bp_done: got %0d pulses required 1", done_count); end
    if (!PREFETCH) begin
      vectors++;
      if (rden_count != 0) begin miscompares++; $display("FAIL bp_rden: got %0d strobes required 0", rden_count); end
    end
  endtask

  task automatic test_zero_passes();
    run_job(12'h123, 12'h010, 10'd0, 100, -1, 20);
    vectors++;
    if (got_q.size() != 0) begin miscompares++; $display("FAIL zero_pairs: got %0d pairs required 0", got_q.size()); end
    vectors++;
    if (done_cycle != 1 || done_count != 1) begin
      miscompares++; $display("FAIL zero_done: got cycle=%0d pulses=%0d required cycle 1, 1 pulse", done_cycle, done_count);
    end
  endtask

  task automatic test_addr_wrap();
    run_job(12'hFF8, 12'h008, 10'd2, 60, -1, 200);
    build_exp(12'hFF8, 12'h008, 2);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL wrap_count: got %0d pairs required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL wrap_pair[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > N) begin
      vectors++;
      if (got_q[0] !== {12'h002, 12'hFFA} || got_q[N] !== {12'h00A, 12'h002}) begin
        miscompares++; $display("FAIL wrap_bases: got %h / %h required 002ffa / 00a002", got_q[0], got_q[N]);
      end
    end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) begin
      logic [AW-1:0] base;
      logic [AW-1:0] stride;
      int            nk;
      int            pct;
      base = AW'($urandom); stride = AW'($urandom);
      nk = $urandom_range(1, 4); pct = $urandom_range(20, 100);
      run_job(base, stride, KW'(nk), pct, 3, 400);
      build_exp(base, stride, nk);
      vectors++;
      if (got_q.size() != exp_q.size() || done_count != 1 || stall_err != 0) begin
        miscompares++;
        $display("FAIL rand%0d_summary: got pairs=%0d done=%0d unstable=%0d required %0d/1/0",
                 j, got_q.size(), done_count, stall_err, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand%0d_pair[%0d]: got %h required %h", j, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_kernels = 10'd3; bus.krnl_base_addr = 12'h200;
    bus.krnl_stride = 12'h040; bus.wht_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.wht_valid !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_pre: got valid=%b busy=%b required 1 1", bus.wht_valid, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.wht_valid, bus.tbl_rden, bus.tbl_rdAddr, bus.wht_addr0, bus.wht_addr1} !== '0) begin
      miscompares++;
      $display("FAIL abort_async: got busy=%b done=%b valid=%b rden=%b rdAddr=%0h a0=%h a1=%h required all 0",
               bus.busy, bus.done, bus.wht_valid, bus.tbl_rden, bus.tbl_rdAddr, bus.wht_addr0, bus.wht_addr1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.wht_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done || bus.wht_valid || bus.busy) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles required 0", dones); end
    bus.wht_ready = 1'b0;
  endtask

  task automatic test_recover();
    run_job(12'h7F0, 12'h100, 10'd1, 100, -1, 60);
    build_exp(12'h7F0, 12'h100, 1);
    vectors++;
    if (got_q.size() != exp_q.size() || done_count != 1) begin
      miscompares++; $display("FAIL recover_count: got %0d pairs %0d done required %0d and 1", got_q.size(), done_count, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL recover_pair[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_passes();
    test_addr_wrap();
    test_random_jobs();
    test_reset_abort();
    test_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
